// File: rtl/queue_controller.sv
// Circular-buffer queue with registered status flags and wrap-bit pointers.
// Optional sticky Overflow/Underflow error flags are enabled by defining QUEUE_ERR_FLAGS_EN.
module queue_controller #(
  parameter int numOfBit = 10,
  parameter int depth    = 8,
  parameter int addrBits = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                WriteEn,
  input  logic [numOfBit-1:0] DataIn,
  input  logic                ReadEn,
`ifdef QUEUE_ERR_FLAGS_EN
  input  logic                ClearErr,
  output logic                Overflow,
  output logic                Underflow,
`endif
  output logic [numOfBit-1:0] DataOut,
  output logic                isFull,
  output logic                isEmpty,
  output logic [addrBits:0]   Count
);

  localparam logic [addrBits:0] ptrOne   = {{addrBits{1'b0}}, 1'b1};
  localparam logic [addrBits:0] wrapMask = {1'b1, {addrBits{1'b0}}};

  // Same equal-compare used by the Comparator block.
  function automatic logic ptrEqual(input logic [addrBits:0] a, input logic [addrBits:0] b);
    ptrEqual = (a == b);
  endfunction

  logic [numOfBit-1:0] mem_r [depth];
  logic [addrBits:0]   wrPtr_r;
  logic [addrBits:0]   rdPtr_r;
  logic [numOfBit-1:0] dataOut_r;
  logic                isFull_r;
  logic                isEmpty_r;
  logic [addrBits:0]   count_r;

  logic                wrAcc_s;
  logic                rdAcc_s;
  logic [addrBits:0]   wrPtrNext_s;
  logic [addrBits:0]   rdPtrNext_s;
  logic [addrBits:0]   countNext_s;
  logic                emptyNext_s;
  logic                fullNext_s;

  // Accept decisions and next pointer/flag values from pre-edge state.
  always_comb begin
    wrAcc_s = WriteEn & ~isFull_r;
    rdAcc_s = ReadEn & ~isEmpty_r;
    if (wrAcc_s) begin
      wrPtrNext_s = wrPtr_r + ptrOne;
    end else begin
      wrPtrNext_s = wrPtr_r;
    end
    if (rdAcc_s) begin
      rdPtrNext_s = rdPtr_r + ptrOne;
    end else begin
      rdPtrNext_s = rdPtr_r;
    end
    countNext_s = wrPtrNext_s - rdPtrNext_s;
    emptyNext_s = ptrEqual(wrPtrNext_s, rdPtrNext_s);
    // Full when only the wrap bit differs: flip it and reuse the equal-compare.
    fullNext_s  = ptrEqual(wrPtrNext_s, rdPtrNext_s ^ wrapMask);
  end

  // Storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wrAcc_s) begin
      mem_r[wrPtr_r[addrBits-1:0]] <= DataIn;
    end
  end

  // Pointer, flag, count and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_r   <= '0;
      rdPtr_r   <= '0;
      dataOut_r <= '0;
      isFull_r  <= 1'b0;
      isEmpty_r <= 1'b1;
      count_r   <= '0;
    end else begin
      wrPtr_r   <= wrPtrNext_s;
      rdPtr_r   <= rdPtrNext_s;
      isFull_r  <= fullNext_s;
      isEmpty_r <= emptyNext_s;
      count_r   <= countNext_s;
      if (rdAcc_s) begin
        dataOut_r <= mem_r[rdPtr_r[addrBits-1:0]];
      end
    end
  end

  assign DataOut = dataOut_r;
  assign isFull  = isFull_r;
  assign isEmpty = isEmpty_r;
  assign Count   = count_r;

`ifdef QUEUE_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; clearing wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (ClearErr) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (WriteEn && isFull_r) begin
        overflow_r <= 1'b1;
      end
      if (ReadEn && isEmpty_r) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign Overflow  = overflow_r;
  assign Underflow = underflow_r;
`endif

endmodule

// File: tb/tb_queue_controller.sv
// Directed-vector bench for queue_controller; read data checked by a scoreboard monitor.
module tb_queue_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       WriteEn = 1'b0;
  logic       ReadEn = 1'b0;
  logic [9:0] DataIn = 10'd0;
  logic [9:0] DataOut;
  logic       isFull;
  logic       isEmpty;
  logic [3:0] Count;
`ifdef QUEUE_ERR_FLAGS_EN
  logic       ClearErr = 1'b0;
  logic       Overflow;
  logic       Underflow;
`endif

  int tests = 0;
  int failed = 0;
  logic [9:0] expQ[$];
  logic expRead = 1'b0;
  logic pend = 1'b0;

  queue_controller #(.numOfBit(10), .depth(8), .addrBits(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .WriteEn(WriteEn),
    .DataIn(DataIn),
    .ReadEn(ReadEn),
`ifdef QUEUE_ERR_FLAGS_EN
    .ClearErr(ClearErr),
    .Overflow(Overflow),
    .Underflow(Underflow),
`endif
    .DataOut(DataOut),
    .isFull(isFull),
    .isEmpty(isEmpty),
    .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one cycle after an expected-accepted read edge, pop and compare DataOut.
  always @(posedge clk) pend <= expRead;

  always @(negedge clk) begin : monitor
    logic [9:0] e;
    if (pend) begin
      tests++;
      if (expQ.size() == 0) begin
        failed++;
        $display("FAIL rd_data: got %0d, expected nothing queued at %0t", DataOut, $time);
      end else begin
        e = expQ.pop_front();
        if (DataOut !== e) begin
          failed++;
          $display("FAIL rd_data: got %0d, expected %0d at %0t", DataOut, e, $time);
        end
      end
    end
  end

  task automatic step(input logic we, input logic [9:0] din, input logic re,
                      input logic expR, input logic [9:0] expD);
    WriteEn = we;
    DataIn  = din;
    ReadEn  = re;
    expRead = expR;
    if (expR) expQ.push_back(expD);
    @(posedge clk);
    #1;
    WriteEn = 1'b0;
    ReadEn  = 1'b0;
    expRead = 1'b0;
  endtask

  task automatic wr(input logic [9:0] d);
    step(1'b1, d, 1'b0, 1'b0, 10'd0);
  endtask

  task automatic rd(input logic [9:0] e);
    step(1'b0, 10'd0, 1'b1, 1'b1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w4[4];
    w4 = '{15, 7, 9, 8};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_empty", isEmpty, 1);
    chk("rst_full", isFull, 0);
    chk("rst_count", Count, 0);
    chk("rst_dout", DataOut, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk("idle_empty", isEmpty, 1);
    chk("idle_full", isFull, 0);
    chk("idle_count", Count, 0);
    chk("idle_dout", DataOut, 0);

    // Basic write 4 / read 4
    for (int i = 0; i < 4; i++) begin
      wr(10'(w4[i]));
      chk("b4_wcount", Count, i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      rd(10'(w4[i]));
      chk("b4_rcount", Count, 3 - i);
    end
    chk("b4_empty", isEmpty, 1);

    // Fill to full, overflow write dropped
    for (int i = 1; i <= 8; i++) wr(10'(i));
    chk("full_flag", isFull, 1);
    chk("full_count", Count, 8);
    wr(10'd99);
    chk("full_drop_count", Count, 8);
    chk("full_drop_flag", isFull, 1);
    for (int i = 1; i <= 8; i++) rd(10'(i));
    chk("drain_empty", isEmpty, 1);
    chk("drain_count", Count, 0);

    // Wrap-around: 6 in, 5 out, 6 in, 7 out
    for (int i = 0; i < 6; i++) wr(10'(10 + i));
    chk("wrap_c6", Count, 6);
    for (int i = 0; i < 5; i++) rd(10'(10 + i));
    chk("wrap_c1", Count, 1);
    for (int i = 0; i < 6; i++) wr(10'(20 + i));
    chk("wrap_peak", Count, 7);
    chk("wrap_notfull", isFull, 0);
    rd(10'd15);
    for (int i = 0; i < 6; i++) rd(10'(20 + i));
    chk("wrap_empty", isEmpty, 1);

    // Simultaneous read/write at Count=3
    wr(10'd31); wr(10'd32); wr(10'd33);
    step(1'b1, 10'd34, 1'b1, 1'b1, 10'd31);
    chk("sim_mid_count", Count, 3);
    rd(10'd32); rd(10'd33); rd(10'd34);
    chk("sim_mid_empty", isEmpty, 1);

    // Simultaneous when empty: write only, no bypass
    step(1'b1, 10'd40, 1'b1, 1'b0, 10'd0);
    chk("sim_empty_count", Count, 1);
    chk("sim_empty_dout", DataOut, 34);
    rd(10'd40);

    // Simultaneous when full: read only, write dropped
    for (int i = 0; i < 8; i++) wr(10'(50 + i));
    step(1'b1, 10'd60, 1'b1, 1'b1, 10'd50);
    chk("sim_full_count", Count, 7);
    chk("sim_full_flag", isFull, 0);
    for (int i = 1; i < 8; i++) rd(10'(50 + i));
    chk("sim_full_empty", isEmpty, 1);

    // Rejected read when empty
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
    chk("rej_rd_dout", DataOut, 57);
    chk("rej_rd_count", Count, 0);

    // Asynchronous reset mid-fill
    wr(10'd61); wr(10'd62); wr(10'd63);
    chk("mid_count", Count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", Count, 0);
    chk("arst_empty", isEmpty, 1);
    chk("arst_dout", DataOut, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
    chk("post_rst_rd_count", Count, 0);
    chk("post_rst_rd_dout", DataOut, 0);
    wr(10'd70);
    rd(10'd70);
    chk("post_rst_empty", isEmpty, 1);

`ifdef QUEUE_ERR_FLAGS_EN
    chk("err_ovf_init", Overflow, 0);
    chk("err_udf_init", Underflow, 0);
    for (int i = 0; i < 8; i++) wr(10'(80 + i));
    wr(10'd99);
    chk("err_ovf_set", Overflow, 1);
    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk("err_ovf_hold", Overflow, 1);
    chk("err_udf_quiet", Underflow, 0);
    for (int i = 0; i < 8; i++) rd(10'(80 + i));
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
    chk("err_udf_set", Underflow, 1);
    ClearErr = 1'b1;
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd0);
    ClearErr = 1'b0;
    chk("err_clr_ovf", Overflow, 0);
    chk("err_clr_udf", Underflow, 0);
`endif

    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0);
    chk("sb_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/queue_controller.md
Name: queue_controller

Overview:
- Synchronous circular-buffer queue: owns storage, read/write pointers and status flags.
- Full/empty come from equality comparison of the pointer pair, each pointer carrying an extra wrap bit, using the same equal-compare function as the team's Comparator block.
- Sits between a producer and a consumer in the queue datapath; one clock domain only.

Parameters:
- numOfBit, 10, width of each data word.
- depth, 8, number of entries; must be a power of two, at least 2.
- addrBits, 3, log2(depth); pointers are addrBits+1 bits wide (MSB is the wrap bit).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- WriteEn  input  1  write request; DataIn is captured when accepted.
- DataIn  input  numOfBit  write data.
- ReadEn  input  1  read request.
- DataOut  output  numOfBit  registered read data.
- isFull  output  1  queue holds depth entries.
- isEmpty  output  1  queue holds 0 entries.
- Count  output  addrBits+1  number of valid entries, 0..depth.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - wrPtr = 0, rdPtr = 0, Count = 0.
  - isEmpty = 1, isFull = 0, DataOut = 0.
  - Storage contents are don't-care.
- Accept rules, evaluated on each rising clk edge using pre-edge state:
  - wrAcc = WriteEn && !isFull.
  - rdAcc = ReadEn && !isEmpty.
- Write: on wrAcc, mem[wrPtr[addrBits-1:0]] <= DataIn and wrPtr <= wrPtr+1 (modulo 2^(addrBits+1)).
- Read: on rdAcc, DataOut <= mem[rdPtr[addrBits-1:0]] and rdPtr <= rdPtr+1. DataOut holds its value on all other cycles. Read latency is 1 cycle from the accepting edge.
- Simultaneous read and write:
  - Both accepted when not full and not empty; Count unchanged.
  - When full: only the read is accepted; the write is dropped.
  - When empty: only the write is accepted; no bypass, so DataOut does not show the new word.
- Flags are registered and derived from next pointer values:
  - isEmpty = (wrPtr == rdPtr), all bits equal.
  - isFull = low addrBits bits equal and wrap bits differ.
  - Count = wrPtr - rdPtr, modulo 2^(addrBits+1).
  - Flags and Count update on the same edge as the pointer change.
- Wrap-around: low pointer bits wrap from depth-1 to 0 and the wrap bit toggles. There are no bubbles or lost entries across the wrap.
- Rejected requests (write when full, read when empty) leave storage, pointers, Count and DataOut unchanged.
- Reset asserted mid-operation discards all entries. The first read after reset release is rejected until a write has occurred.

Optional Feature:
- Macro: QUEUE_ERR_FLAGS_EN.
- When defined, the block adds:
  - ports Overflow output 1, Underflow output 1, ClearErr input 1;
  - Overflow sets (sticky) on the edge where WriteEn=1 and isFull=1;
  - Underflow sets (sticky) on the edge where ReadEn=1 and isEmpty=1;
  - ClearErr=1 clears both flags on the next edge, and clear takes priority over set in the same cycle;
  - both flags reset to 0.
- When not defined: these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then idle 2 cycles -> isEmpty=1, isFull=0, Count=0, DataOut=0.
- (depth=8, numOfBit=10) Write 15, 7, 9, 8 on consecutive cycles, then read 4 -> Count goes 1,2,3,4 then 3,2,1,0. DataOut is 15, 7, 9, 8, each one cycle after its read edge. isEmpty=1 at end.
- Write 8 words 1..8 -> isFull=1, Count=8. A 9th write of 99 is dropped. Reading 8 words returns 1..8 and the value 99 never appears.
- Fill with 6 words, read 5, write 6 more (pointers wrap) -> reads return the correct FIFO order across the wrap; Count peaks at 7.
- Simultaneous WriteEn/ReadEn:
  - at Count=3 -> Count stays 3;
  - when empty -> Count becomes 1, DataOut unchanged;
  - when full -> Count becomes 7, written data not stored.
- With QUEUE_ERR_FLAGS_EN defined:
  - write when full -> Overflow=1 and holds;
  - read when empty -> Underflow=1;
  - ClearErr=1 -> both 0 on the next edge;
  - rst_n pulse mid-fill -> Count=0 asynchronously.
